// File: rtl/pair_triple_arbiter_if.sv
// Requester and response handshake bundle for pair_triple_arbiter.
// master = requesters plus consumer (the environment); slave = the arbiter.
interface pair_triple_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [3*NREQ-1:0] req_bits;
  logic              resp_val;
  logic              resp_rdy;
  logic              resp_out;
  logic [IDW-1:0]    resp_id;
  logic [7:0]        svc_count;

  modport master (
    output req_val, req_bits, resp_rdy,
    input  req_rdy, resp_val, resp_out, resp_id, svc_count
  );

  modport slave (
    input  req_val, req_bits, resp_rdy,
    output req_rdy, resp_val, resp_out, resp_id, svc_count
  );
endinterface

// File: rtl/pair_triple_arbiter.sv
// Round-robin arbiter that shares one "two-of-three" detector between NREQ
// requesters. Each result is tagged with its requester index and held in a
// single-entry response buffer. The buffer can drain and refill on the same edge.
module pair_triple_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pair_triple_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t         state_q, state_d;
  logic           out_q, out_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [IDW:0]   sum_w    [NREQ];
  logic [IDW-1:0] cand_idx [NREQ];
  logic [2:0]     votes    [NREQ];

  logic           can_accept;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic           xfer;
  logic [2:0]     vote;
  logic           det;

  // Scan order starting at the priority pointer, plus the per-requester votes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
    assign sum_w[gi]    = {1'b0, ptr_q} + (IDW+1)'(gi);
    assign cand_idx[gi] = (sum_w[gi] >= NREQ_W) ? IDW'(sum_w[gi] - NREQ_W)
                                                : IDW'(sum_w[gi]);
    assign votes[gi]    = bus.req_bits[3*gi +: 3];
  end

  // The buffer accepts a new entry when it is empty, or when it drains this cycle.
  assign can_accept = (state_q == EMPTY) | ((state_q == FULL) & bus.resp_rdy);

  // Select the first valid requester in rotated order. The loop runs backwards
  // so that the entry closest to the pointer overwrites the others and wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_val[cand_idx[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx[k];
      end
    end
  end

  // rst_n gates the grant because reset holds the state at EMPTY, which would
  // otherwise allow a grant while reset is active.
  assign xfer        = gnt_any & can_accept & rst_n;
  assign bus.req_rdy = xfer ? (NREQ'(1) << gnt_idx) : '0;

  assign vote = votes[gnt_idx];
  assign det  = (vote[0] & vote[1]) | ((vote[0] | vote[1]) & vote[2]);

  // Next state for the buffer FSM, the pointer and the service counter.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (bus.resp_rdy && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      out_d = det;
      id_d  = gnt_idx;
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers. Reset discards any pending response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.resp_val  = (state_q == FULL);
  assign bus.resp_out  = out_q;
  assign bus.resp_id   = id_q;
  assign bus.svc_count = cnt_q;

endmodule

// File: tb/tb_pair_triple_arbiter.sv
// Directed testbench for pair_triple_arbiter with NREQ=4.
module tb_pair_triple_arbiter;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  pair_triple_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  pair_triple_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse the asynchronous reset between clock edges.
  task automatic pulse_reset();
    bus.req_val  = 4'b0000;
    bus.req_bits = 12'b0;
    bus.resp_rdy = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.req_val  = 4'b1111;
    bus.req_bits = 12'hFFF;
    bus.resp_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.resp_val !== 1'b0) $display("FAIL reset_resp_val got=%b exp=0", bus.resp_val);
    else pass_cnt++;
    total_cnt++;
    if (bus.resp_out !== 1'b0) $display("FAIL reset_resp_out got=%b exp=0", bus.resp_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.resp_id !== 2'd0) $display("FAIL reset_resp_id got=%0d exp=0", bus.resp_id);
    else pass_cnt++;
    total_cnt++;
    if (bus.svc_count !== 8'd0) $display("FAIL reset_svc got=%0d exp=0", bus.svc_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.req_rdy !== 4'b0000) $display("FAIL reset_req_rdy got=%b exp=0000", bus.req_rdy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.resp_val !== 1'b0 || bus.req_rdy !== 4'b0000)
      $display("FAIL reset_held_edge got val=%b rdy=%b exp val=0 rdy=0000", bus.resp_val, bus.req_rdy);
    else pass_cnt++;
    $display("reset: rdy=%b val=%b svc=%0d", bus.req_rdy, bus.resp_val, bus.svc_count);
    rst_n = 1'b1;
    bus.req_val = 4'b0000;
  endtask

  task automatic test_truth_table();
    logic [7:0] exp_tbl;
    exp_tbl = 8'b1110_1000;  // bit v = expected output for vote v
    pulse_reset();
    bus.req_val  = 4'b0001;
    bus.resp_rdy = 1'b1;
    for (int v = 0; v < 8; v++) begin
      bus.req_bits = {9'b0, 3'(v)};
      step();
      $display("truth: bits=%03b out=%b id=%0d val=%b", 3'(v), bus.resp_out, bus.resp_id, bus.resp_val);
      total_cnt++;
      if (bus.resp_val !== 1'b1 || bus.resp_out !== exp_tbl[v] || bus.resp_id !== 2'd0)
        $display("FAIL truth_%0d got val=%b out=%b id=%0d exp val=1 out=%b id=0",
                 v, bus.resp_val, bus.resp_out, bus.resp_id, exp_tbl[v]);
      else pass_cnt++;
    end
    bus.req_val = 4'b0000;
    step();
    total_cnt++;
    if (bus.resp_val !== 1'b0 || bus.svc_count !== 8'd8)
      $display("FAIL truth_drain got val=%b svc=%0d exp val=0 svc=8", bus.resp_val, bus.svc_count);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_out;
    exp_out = 4'b1101;  // req3=111, req2=110, req1=001, req0=011
    pulse_reset();
    bus.req_bits = 12'b111_110_001_011;
    bus.req_val  = 4'b1111;
    bus.resp_rdy = 1'b1;
    #1;
    total_cnt++;
    if (bus.req_rdy !== 4'b0001) $display("FAIL rr_first_rdy got=%b exp=0001", bus.req_rdy);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      step();
      $display("rr: cycle=%0d id=%0d out=%b", k, bus.resp_id, bus.resp_out);
      total_cnt++;
      if (bus.resp_id !== 2'(k % 4) || bus.resp_out !== exp_out[k % 4] || bus.resp_val !== 1'b1)
        $display("FAIL rr_%0d got id=%0d out=%b val=%b exp id=%0d out=%b val=1",
                 k, bus.resp_id, bus.resp_out, bus.resp_val, k % 4, exp_out[k % 4]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.svc_count !== 8'd8) $display("FAIL rr_svc got=%0d exp=8", bus.svc_count);
    else pass_cnt++;
    bus.req_val = 4'b0000;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    bus.req_bits = 12'b100_000_110_000;  // req3=100 -> 0, req1=110 -> 1
    bus.req_val  = 4'b1010;
    bus.resp_rdy = 1'b0;
    step();
    bus.req_val = 4'b1000;  // requester 1 was accepted
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("bp: cycle=%0d id=%0d out=%b rdy=%b svc=%0d", k, bus.resp_id, bus.resp_out, bus.req_rdy, bus.svc_count);
      total_cnt++;
      if (bus.resp_val !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_out !== 1'b1 ||
          bus.req_rdy !== 4'b0000 || bus.svc_count !== 8'd1)
        $display("FAIL bp_hold_%0d got val=%b id=%0d out=%b rdy=%b svc=%0d exp val=1 id=1 out=1 rdy=0000 svc=1",
                 k, bus.resp_val, bus.resp_id, bus.resp_out, bus.req_rdy, bus.svc_count);
      else pass_cnt++;
      if (k < 2) step();
    end
    bus.resp_rdy = 1'b1;
    #1;
    total_cnt++;
    if (bus.req_rdy !== 4'b1000) $display("FAIL bp_release_rdy got=%b exp=1000", bus.req_rdy);
    else pass_cnt++;
    step();
    bus.req_val = 4'b0000;
    total_cnt++;
    if (bus.resp_val !== 1'b1 || bus.resp_id !== 2'd3 || bus.resp_out !== 1'b0 || bus.svc_count !== 8'd2)
      $display("FAIL bp_refill got val=%b id=%0d out=%b svc=%0d exp val=1 id=3 out=0 svc=2",
               bus.resp_val, bus.resp_id, bus.resp_out, bus.svc_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.resp_val !== 1'b0) $display("FAIL bp_drain got val=%b exp=0", bus.resp_val);
    else pass_cnt++;
  endtask

  task automatic test_pointer_skip();
    pulse_reset();
    bus.req_bits = 12'b011_011_011_011;
    bus.resp_rdy = 1'b1;
    bus.req_val  = 4'b1000;
    step();
    total_cnt++;
    if (bus.resp_id !== 2'd3) $display("FAIL skip_first got id=%0d exp=3", bus.resp_id);
    else pass_cnt++;
    bus.req_val = 4'b0010;
    #1;
    total_cnt++;
    if (bus.req_rdy !== 4'b0010) $display("FAIL skip_rdy1 got=%b exp=0010", bus.req_rdy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.resp_id !== 2'd1) $display("FAIL skip_id1 got id=%0d exp=1", bus.resp_id);
    else pass_cnt++;
    bus.req_val = 4'b0011;
    #1;
    total_cnt++;
    if (bus.req_rdy !== 4'b0001) $display("FAIL skip_rdy0 got=%b exp=0001", bus.req_rdy);
    else pass_cnt++;
    step();
    $display("skip: id=%0d svc=%0d", bus.resp_id, bus.svc_count);
    total_cnt++;
    if (bus.resp_id !== 2'd0) $display("FAIL skip_id0 got id=%0d exp=0", bus.resp_id);
    else pass_cnt++;
    bus.req_val = 4'b0000;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    bus.req_bits = 12'b011_000_000_000;
    bus.req_val  = 4'b1000;
    bus.resp_rdy = 1'b0;
    step();
    total_cnt++;
    if (bus.resp_val !== 1'b1 || bus.resp_id !== 2'd3)
      $display("FAIL mid_full got val=%b id=%0d exp val=1 id=3", bus.resp_val, bus.resp_id);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.resp_val !== 1'b0 || bus.resp_id !== 2'd0 || bus.resp_out !== 1'b0 ||
        bus.svc_count !== 8'd0 || bus.req_rdy !== 4'b0000)
      $display("FAIL mid_reset got val=%b id=%0d out=%b svc=%0d rdy=%b exp val=0 id=0 out=0 svc=0 rdy=0000",
               bus.resp_val, bus.resp_id, bus.resp_out, bus.svc_count, bus.req_rdy);
    else pass_cnt++;
    rst_n = 1'b1;
    bus.req_bits = 12'b000_101_000_000;
    bus.req_val  = 4'b0100;
    bus.resp_rdy = 1'b1;
    step();
    $display("mid: id=%0d out=%b val=%b", bus.resp_id, bus.resp_out, bus.resp_val);
    total_cnt++;
    if (bus.resp_val !== 1'b1 || bus.resp_out !== 1'b1 || bus.resp_id !== 2'd2)
      $display("FAIL mid_after got val=%b out=%b id=%0d exp val=1 out=1 id=2",
               bus.resp_val, bus.resp_out, bus.resp_id);
    else pass_cnt++;
    bus.req_val = 4'b0000;
  endtask

  task automatic test_counter_wrap();
    pulse_reset();
    bus.req_bits = 12'b0;
    bus.req_val  = 4'b0001;
    bus.resp_rdy = 1'b1;
    for (int k = 0; k < 255; k++) step();
    total_cnt++;
    if (bus.svc_count !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", bus.svc_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.svc_count !== 8'd0) $display("FAIL wrap_256 got=%0d exp=0", bus.svc_count);
    else pass_cnt++;
    step();
    $display("wrap: svc=%0d", bus.svc_count);
    total_cnt++;
    if (bus.svc_count !== 8'd1) $display("FAIL wrap_257 got=%0d exp=1", bus.svc_count);
    else pass_cnt++;
    bus.req_val = 4'b0000;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b1;
    bus.req_val  = 4'b0000;
    bus.req_bits = 12'b0;
    bus.resp_rdy = 1'b0;
    test_reset();
    test_truth_table();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
